// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if
//   Bundles every MemoryBus signal seen by the N:1 arbiter. That covers the
//   per-master request/response lanes (mReq*/mRsp*), the request channel to
//   the memory slave (ms*), and the response channel from it (sm*).
//
//   Handshake rule for every channel: a beat moves only in a cycle where the
//   channel's valid and taken are both high. The source holds valid and
//   payload stable until it sees taken.
//
//   Modports
//     slave  : the arbiter itself. It receives the masters' requests and the
//              slave's responses, and drives grants, ms* and routed responses.
//     master : the surrounding system (upstream masters plus memory slave).
//              This is the mirror image of slave.
//
//   Packed request lanes: master i occupies [i*W +: W] of mReqAddress and
//   mReqData.
interface memory_arbiter_if #(
    parameter int MASTERS    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 24,
    parameter int ID_WIDTH   = 8
);
    logic [MASTERS-1:0]            mReqValid;
    logic [MASTERS-1:0]            mReqTaken;
    logic [MASTERS*ADDR_WIDTH-1:0] mReqAddress;
    logic [MASTERS*DATA_WIDTH-1:0] mReqData;
    logic [MASTERS-1:0]            mReqWrite;
    logic [MASTERS-1:0]            mRspValid;
    logic [MASTERS-1:0]            mRspTaken;
    logic [DATA_WIDTH-1:0]         mRspData;

    logic                          msValid;
    logic                          msTaken;
    logic [ADDR_WIDTH-1:0]         msAddress;
    logic [DATA_WIDTH-1:0]         msData;
    logic                          msWrite;
    logic [ID_WIDTH-1:0]           msID;

    logic                          smValid;
    logic                          smTaken;
    logic [DATA_WIDTH-1:0]         smData;
    logic [ID_WIDTH-1:0]           smID;

    modport slave (
        input  mReqValid, mReqAddress, mReqData, mReqWrite, mRspTaken,
        input  msTaken, smValid, smData, smID,
        output mReqTaken, mRspValid, mRspData,
        output msValid, msAddress, msData, msWrite, msID, smTaken
    );

    modport master (
        output mReqValid, mReqAddress, mReqData, mReqWrite, mRspTaken,
        output msTaken, smValid, smData, smID,
        input  mReqTaken, mRspValid, mRspData,
        input  msValid, msAddress, msData, msWrite, msID, smTaken
    );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   N-master to 1-slave MemoryBus arbiter.
//
//   Request path: a combinational round-robin search picks one requesting
//   master. The search starts at r_ptr. The winner's payload is loaded into
//   a one-entry output register that drives ms*, and msID is stamped with
//   the winner's index. The register can reload in the same cycle it is
//   drained, so back-to-back requests stream at one per cycle.
//
//   Response path: purely combinational. smID selects the master lane. A beat
//   whose smID names no master is accepted immediately and discarded, and it
//   is counted in a saturating 8-bit counter.
//
//   Ports
//     clock     : single clock, rising edge
//     reset     : synchronous, active high
//     bus       : memory_arbiter_if.slave (all request/response channels)
//     dropCount : number of discarded responses, saturates at 255
module memory_arbiter #(
    parameter int MASTERS    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 24,
    parameter int ID_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    memory_arbiter_if.slave        bus,
    output logic [7:0]             dropCount
);
    localparam int PTR_W = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    // Output stage and arbitration state.
    logic                  r_full;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_write;
    logic [ID_WIDTH-1:0]   r_id;
    logic [PTR_W-1:0]      r_ptr;
    logic [7:0]            r_drop;

    logic                  w_can_load;
    logic                  w_any_req;
    logic                  w_grant;
    logic [PTR_W-1:0]      w_gnt_idx;
    logic [PTR_W-1:0]      w_ptr_next;
    logic [MASTERS-1:0]    w_req_taken;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_write;

    logic                  w_routable;
    logic                  w_sel_rsp_taken;
    logic [MASTERS-1:0]    w_rsp_valid;

    // The stage can accept a new request when it is empty, or when its
    // current content leaves this cycle.
    assign w_can_load = !r_full || (r_full && bus.msTaken);

    // Round-robin search. Offsets are scanned from the far end toward
    // offset 0, so the last hit is the requester closest to r_ptr. That
    // gives a priority search without an early exit.
    always_comb begin
        int idx;
        w_any_req = 1'b0;
        w_gnt_idx = '0;
        for (int k = MASTERS - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= MASTERS) begin
                idx = idx - MASTERS;
            end
            if (bus.mReqValid[idx]) begin
                w_any_req = 1'b1;
                w_gnt_idx = idx[PTR_W-1:0];
            end
        end
    end

    // Reset gates the grant so no master sees its request consumed by a
    // stage that is about to be cleared.
    assign w_grant = w_can_load && w_any_req && !reset;

    always_comb begin
        w_req_taken = '0;
        for (int i = 0; i < MASTERS; i++) begin
            w_req_taken[i] = w_grant && (w_gnt_idx == PTR_W'(i));
        end
    end

    assign w_sel_addr  = bus.mReqAddress[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_data  = bus.mReqData[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_write = bus.mReqWrite[w_gnt_idx];
    assign w_ptr_next  = (w_gnt_idx == PTR_W'(MASTERS - 1)) ? '0 : w_gnt_idx + 1'b1;

    // Response routing. Matching against each lane index avoids comparing
    // smID to MASTERS directly. A direct compare would wrap when
    // MASTERS == 2**ID_WIDTH.
    always_comb begin
        w_routable      = 1'b0;
        w_sel_rsp_taken = 1'b0;
        w_rsp_valid     = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (bus.smID == ID_WIDTH'(i)) begin
                w_routable      = 1'b1;
                w_sel_rsp_taken = bus.mRspTaken[i];
                w_rsp_valid[i]  = bus.smValid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_full  <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_write <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_drop  <= '0;
        end else begin
            if (w_grant) begin
                r_full  <= 1'b1;
                r_addr  <= w_sel_addr;
                r_data  <= w_sel_data;
                r_write <= w_sel_write;
                r_id    <= ID_WIDTH'(w_gnt_idx);
                r_ptr   <= w_ptr_next;
            end else if (bus.msTaken) begin
                r_full  <= 1'b0;
            end
            // Unroutable beats are always taken, so every valid one is a drop.
            if (bus.smValid && !w_routable && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign bus.mReqTaken = w_req_taken;
    assign bus.msValid   = r_full;
    assign bus.msAddress = r_addr;
    assign bus.msData    = r_data;
    assign bus.msWrite   = r_write;
    assign bus.msID      = r_id;

    assign bus.mRspValid = w_rsp_valid;
    assign bus.mRspData  = bus.smData;
    assign bus.smTaken   = w_routable ? w_sel_rsp_taken : 1'b1;

    assign dropCount = r_drop;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
//   Inputs change 1 time unit after the rising edge. Outputs are examined at
//   the falling edge. The reference model tracks the stage as a full flag plus
//   the last loaded request, and keeps the pointer as an integer updated with
//   modulo arithmetic. A queue holds the granted requests in order.
module tb_memory_arbiter;
    localparam int M   = 4;
    localparam int AW  = 32;
    localparam int DW  = 24;
    localparam int IW  = 8;
    localparam int SBW = 1 + IW + AW + DW;

    logic       clock;
    logic       reset;
    logic [7:0] dropCount;

    memory_arbiter_if #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus();

    memory_arbiter #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dropCount (dropCount)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    int          m_ptr   = 0;
    bit          m_full  = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit          m_write = 1'b0;
    int          m_id    = 0;
    int          m_drop  = 0;
    int          m_gnt   = -1;
    logic [SBW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (reset) return -1;
        if (m_full && !bus.msTaken) return -1;
        for (int k = 0; k < M; k++) begin
            int idx;
            idx = (m_ptr + k) % M;
            if (bus.mReqValid[idx]) return idx;
        end
        return -1;
    endfunction

    // Compare every output against the model for the current cycle.
    task automatic mid_check();
        logic [M-1:0]   e_taken;
        logic [M-1:0]   e_rv;
        logic           e_st;
        logic [SBW-1:0] got;
        int             sid;
        m_gnt   = model_grant();
        e_taken = '0;
        if (m_gnt >= 0) e_taken[m_gnt] = 1'b1;
        chk("mReqTaken", bus.mReqTaken, e_taken);
        chk("msValid",   bus.msValid, m_full);
        chk("msAddress", bus.msAddress, m_addr);
        chk("msData",    bus.msData, m_data);
        chk("msWrite",   bus.msWrite, m_write);
        chk("msID",      bus.msID, m_id);
        sid  = int'(bus.smID);
        e_rv = '0;
        e_st = 1'b1;
        if (sid < M) begin
            e_st = bus.mRspTaken[sid];
            if (bus.smValid) e_rv[sid] = 1'b1;
        end
        chk("mRspValid", bus.mRspValid, e_rv);
        chk("smTaken",   bus.smTaken, e_st);
        chk("mRspData",  bus.mRspData, bus.smData);
        chk("dropCount", dropCount, m_drop);
        if (bus.msValid && bus.msTaken) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_order at %0t: slave transfer with nothing granted", $time);
            end else begin
                got = {bus.msWrite, bus.msID, bus.msAddress, bus.msData};
                chk("sb_order", got, exp_q.pop_front());
            end
        end
    endtask

    // Apply the rules for the rising edge that ends this cycle.
    task automatic model_update();
        if (reset) begin
            m_full = 1'b0; m_ptr = 0; m_drop = 0;
            m_addr = '0; m_data = '0; m_write = 1'b0; m_id = 0;
            exp_q.delete();
        end else begin
            if (m_gnt >= 0) begin
                m_full  = 1'b1;
                m_addr  = bus.mReqAddress[m_gnt*AW +: AW];
                m_data  = bus.mReqData[m_gnt*DW +: DW];
                m_write = bus.mReqWrite[m_gnt];
                m_id    = m_gnt;
                m_ptr   = (m_gnt + 1) % M;
                exp_q.push_back({m_write, IW'(m_id), m_addr, m_data});
            end else if (bus.msTaken) begin
                m_full = 1'b0;
            end
            if (bus.smValid && int'(bus.smID) >= M && m_drop < 255) m_drop++;
        end
    endtask

    task automatic advance();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic cycle();
        #4;
        mid_check();
        advance();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.mReqValid = '0;
        bus.mReqWrite = '0;
        bus.mRspTaken = '0;
        bus.msTaken   = 1'b0;
        bus.smValid   = 1'b0;
        bus.smID      = '0;
        bus.smData    = '0;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        bus.mReqAddress[i*AW +: AW] = a;
        bus.mReqData[i*DW +: DW]    = d;
        bus.mReqWrite[i]            = w;
    endtask

    task automatic table_payloads();
        for (int i = 0; i < M; i++) begin
            set_req(i, 32'h0000_1000 + 32'(i) * 32'h100, 24'hA0_0000 + 24'(i), i[0]);
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < n; i++) cycle();
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst;
        logic [M-1:0] req;
        bit          ms_taken;
        bit          sm_valid;
        logic [IW-1:0] sm_id;
        logic [M-1:0] rsp_taken;
        logic [M-1:0] e_taken;
        bit          e_ms_valid;
        logic [IW-1:0] e_ms_id;
        logic [M-1:0] e_rsp_valid;
        bit          e_sm_taken;
    } vec_t;

    vec_t vecs[12];

    int order[6];

    initial begin
        // Start-up: one reset edge before the model is in step with the DUT.
        reset = 1'b1;
        idle_inputs();
        bus.mReqAddress = '0;
        bus.mReqData    = '0;
        @(posedge clock);
        model_update();
        #1;

        // Reset then idle for 10 cycles.
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            #4;
            chk("idle_msValid", bus.msValid, 1'b0);
            chk("idle_mReqTaken", bus.mReqTaken, 4'b0000);
            chk("idle_mRspValid", bus.mRspValid, 4'b0000);
            chk("idle_dropCount", dropCount, 8'd0);
            chk("idle_msID", bus.msID, 8'd0);
            mid_check();
            advance();
        end

        // A single write from master 2 with the slave ready.
        set_req(2, 32'h1000, 24'hABCDEF, 1'b1);
        bus.mReqValid = 4'b0100;
        bus.msTaken   = 1'b1;
        #4;
        chk("m2_taken", bus.mReqTaken, 4'b0100);
        mid_check();
        advance();
        bus.mReqValid = 4'b0000;
        #4;
        chk("m2_msValid", bus.msValid, 1'b1);
        chk("m2_msAddress", bus.msAddress, 32'h1000);
        chk("m2_msData", bus.msData, 24'hABCDEF);
        chk("m2_msWrite", bus.msWrite, 1'b1);
        chk("m2_msID", bus.msID, 8'd2);
        mid_check();
        advance();

        // Table of hand-derived vectors, starting from a clean reset.
        vecs[0]  = '{0, 4'b0000, 0, 0, 8'd0, 4'b0000, 4'b0000, 0, 8'd0, 4'b0000, 0};
        vecs[1]  = '{0, 4'b0100, 1, 0, 8'd0, 4'b0000, 4'b0100, 0, 8'd0, 4'b0000, 0};
        vecs[2]  = '{0, 4'b0000, 1, 1, 8'd1, 4'b0000, 4'b0000, 1, 8'd2, 4'b0010, 0};
        vecs[3]  = '{0, 4'b1001, 0, 1, 8'd1, 4'b0010, 4'b1000, 0, 8'd2, 4'b0010, 1};
        vecs[4]  = '{0, 4'b1001, 0, 0, 8'd2, 4'b0100, 4'b0000, 1, 8'd3, 4'b0000, 1};
        vecs[5]  = '{0, 4'b0001, 1, 0, 8'd0, 4'b0000, 4'b0001, 1, 8'd3, 4'b0000, 0};
        vecs[6]  = '{0, 4'b0000, 1, 1, 8'd5, 4'b0000, 4'b0000, 1, 8'd0, 4'b0000, 1};
        vecs[7]  = '{0, 4'b1111, 1, 0, 8'd0, 4'b0000, 4'b0010, 0, 8'd0, 4'b0000, 0};
        vecs[8]  = '{0, 4'b1111, 1, 0, 8'd0, 4'b0000, 4'b0100, 1, 8'd1, 4'b0000, 0};
        vecs[9]  = '{0, 4'b1111, 1, 0, 8'd0, 4'b0000, 4'b1000, 1, 8'd2, 4'b0000, 0};
        vecs[10] = '{1, 4'b1111, 1, 0, 8'd0, 4'b0000, 4'b0000, 1, 8'd3, 4'b0000, 0};
        vecs[11] = '{0, 4'b1001, 0, 0, 8'd0, 4'b0000, 4'b0001, 0, 8'd0, 4'b0000, 0};
        do_reset(1);
        table_payloads();
        for (int v = 0; v < 12; v++) begin
            reset         = vecs[v].rst;
            bus.mReqValid = vecs[v].req;
            bus.msTaken   = vecs[v].ms_taken;
            bus.smValid   = vecs[v].sm_valid;
            bus.smID      = vecs[v].sm_id;
            bus.mRspTaken = vecs[v].rsp_taken;
            bus.smData    = 24'h00_0100 + 24'(v);
            #4;
            chk("vec_mReqTaken", bus.mReqTaken, vecs[v].e_taken);
            chk("vec_msValid", bus.msValid, vecs[v].e_ms_valid);
            chk("vec_msID", bus.msID, vecs[v].e_ms_id);
            chk("vec_mRspValid", bus.mRspValid, vecs[v].e_rsp_valid);
            chk("vec_smTaken", bus.smTaken, vecs[v].e_sm_taken);
            mid_check();
            advance();
        end
        reset = 1'b0;

        // Fairness: all masters valid, slave always ready.
        do_reset(1);
        table_payloads();
        order = '{0, 1, 2, 3, 0, 1};
        bus.mReqValid = 4'b1111;
        bus.msTaken   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [M-1:0] e;
            e = '0;
            e[order[k]] = 1'b1;
            #4;
            chk("rr_grant", bus.mReqTaken, e);
            if (k > 0) chk("rr_no_bubble", bus.msValid, 1'b1);
            mid_check();
            advance();
        end

        // Slave stall with master 1's request held in the stage.
        bus.msTaken = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #4;
            chk("stall_msValid", bus.msValid, 1'b1);
            chk("stall_mReqTaken", bus.mReqTaken, 4'b0000);
            chk("stall_msAddress", bus.msAddress, 32'h0000_1100);
            chk("stall_msID", bus.msID, 8'd1);
            mid_check();
            advance();
        end
        bus.msTaken = 1'b1;
        #4;
        chk("unstall_grant", bus.mReqTaken, 4'b0100);
        mid_check();
        advance();
        idle_inputs();

        // Response to master 1 held off for three cycles.
        bus.smValid = 1'b1;
        bus.smID    = 8'd1;
        bus.smData  = 24'h123456;
        for (int k = 0; k < 4; k++) begin
            bus.mRspTaken = (k == 3) ? 4'b0010 : 4'b0000;
            #4;
            chk("rsp_mRspValid", bus.mRspValid, 4'b0010);
            chk("rsp_smTaken", bus.smTaken, (k == 3));
            chk("rsp_mRspData", bus.mRspData, 24'h123456);
            mid_check();
            advance();
        end
        idle_inputs();

        // Unroutable responses: always taken, counted, saturating.
        bus.smValid = 1'b1;
        bus.smID    = 8'd7;
        for (int k = 0; k < 300; k++) begin
            #4;
            chk("drop_smTaken", bus.smTaken, 1'b1);
            chk("drop_mRspValid", bus.mRspValid, 4'b0000);
            mid_check();
            advance();
        end
        idle_inputs();
        #4;
        chk("drop_saturated", dropCount, 8'd255);
        mid_check();
        advance();

        // Reset while the stage is full.
        bus.mReqValid = 4'b0001;
        cycle();
        bus.mReqValid = 4'b0000;
        #4;
        chk("full_before_reset", bus.msValid, 1'b1);
        mid_check();
        advance();
        reset = 1'b1;
        bus.mReqValid = 4'b1001;
        #4;
        chk("reset_no_grant", bus.mReqTaken, 4'b0000);
        mid_check();
        advance();
        reset = 1'b0;
        #4;
        chk("post_reset_msValid", bus.msValid, 1'b0);
        chk("post_reset_ptr", bus.mReqTaken, 4'b0001);
        mid_check();
        advance();

        // Randomized traffic against the model.
        idle_inputs();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < M; i++) begin
                if (!bus.mReqValid[i] || m_gnt == i) begin
                    bus.mReqValid[i] = ($urandom_range(0, 99) < 60);
                    set_req(i, $urandom, 24'($urandom), 1'($urandom_range(0, 1)));
                end
            end
            bus.msTaken = ($urandom_range(0, 3) != 0);
            if (!bus.smValid || bus.smTaken) begin
                bus.smValid = ($urandom_range(0, 99) < 50);
                bus.smID    = 8'($urandom_range(0, 5));
                bus.smData  = 24'($urandom);
            end
            bus.mRspTaken = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
